// File: rtl/period_meter_if.sv
// Result handshake bundle for period_meter: captured interval plus valid/ready.
interface period_meter_if #(
   parameter int unsigned N = 16
);
   logic [N-1:0] period_o;
   logic         valid_o;
   logic         ready_i;

   modport master (output period_o, output valid_o, input ready_i);
   modport slave  (input period_o, input valid_o, output ready_i);
endinterface

// File: rtl/period_meter.sv
// Measures clock cycles between rising strobe edges; reports P-1 over a
// valid/ready output register, with sticky overflow and lost-result flags.
module period_meter #(
   parameter int unsigned N = 16
) (
   input  logic            clk_i,
   input  logic            reset,
   input  logic            enable_i,
   input  logic            strobe_i,
   period_meter_if.master  out_if,
   output logic            overflow_o,
   output logic            lost_o,
   output logic            busy_o
);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] ctr_q, ctr_d;
   logic [N-1:0] period_q, period_d;
   logic         valid_q, valid_d;
   logic         ovf_q, ovf_d;
   logic         lost_q, lost_d;
   logic         busy_q;
   logic         strobe_q;
   logic         strobe_edge;
   logic         capture;

   assign strobe_edge = strobe_i & ~strobe_q;

   always_comb begin
      state_d  = state_q;
      ctr_d    = ctr_q;
      ovf_d    = ovf_q;
      lost_d   = lost_q;
      period_d = period_q;
      valid_d  = valid_q;
      capture  = 1'b0;

      if (!enable_i) begin
         state_d = IDLE;
         ctr_d   = '0;
         ovf_d   = 1'b0;
         lost_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = ARM;
            ARM: begin
               if (strobe_edge) begin
                  state_d = MEASURE;
                  ctr_d   = '0;
               end
            end
            MEASURE: begin
               // an edge coinciding with all-ones is a valid capture of 2^N-1
               if (strobe_edge) begin
                  capture = 1'b1;
                  ctr_d   = '0;
               end else if (ctr_q == '1) begin
                  ovf_d   = 1'b1;
                  state_d = ARM;
               end else begin
                  ctr_d = ctr_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (capture) begin
         if (!valid_q || out_if.ready_i) begin
            period_d = ctr_q;
            valid_d  = 1'b1;
         end else begin
            lost_d = 1'b1;
         end
      end else if (valid_q && out_if.ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q  <= IDLE;
         ctr_q    <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         lost_q   <= 1'b0;
         busy_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctr_q    <= ctr_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         lost_q   <= lost_d;
         busy_q   <= (state_d == MEASURE);
         strobe_q <= strobe_i;
      end
   end

   assign out_if.period_o = period_q;
   assign out_if.valid_o  = valid_q;
   assign overflow_o      = ovf_q;
   assign lost_o          = lost_q;
   assign busy_o          = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: table-driven strobe trains scored through a queue,
// plus hand sequences for backpressure, overflow, abort and reset.
module tb_period_meter;

   logic clk = 1'b0;
   logic reset;
   logic en16, strobe16, ovf16, lost16, busy16;
   logic en4, strobe4, ovf4, lost4, busy4;

   int total = 0;
   int bad   = 0;
   logic [15:0] sb[$];

   period_meter_if #(.N(16)) if16 ();
   period_meter_if #(.N(4))  if4 ();

   period_meter #(.N(16)) u_dut16 (
      .clk_i(clk), .reset(reset), .enable_i(en16), .strobe_i(strobe16),
      .out_if(if16.master), .overflow_o(ovf16), .lost_o(lost16), .busy_o(busy16)
   );

   period_meter #(.N(4)) u_dut4 (
      .clk_i(clk), .reset(reset), .enable_i(en4), .strobe_i(strobe4),
      .out_if(if4.master), .overflow_o(ovf4), .lost_o(lost4), .busy_o(busy4)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned period;
      int unsigned hi;
      int unsigned pulses;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one strobe period on the 16-bit unit; push the expected result when the edge will capture
   task automatic pulse16(input int unsigned p, input int unsigned hi, input bit push);
      if (push) sb.push_back(16'(p - 1));
      strobe16 = 1'b1;
      tick();
      repeat (hi - 1) tick();
      strobe16 = 1'b0;
      repeat (p - hi) tick();
   endtask

   always @(negedge clk) begin
      if (!reset && if16.valid_o && if16.ready_i) begin
         if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
         else chk("period", {16'd0, if16.period_o}, {16'd0, sb.pop_front()});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[5];
      vecs[0] = '{period: 10, hi: 1,  pulses: 4};
      vecs[1] = '{period: 2,  hi: 1,  pulses: 6};
      vecs[2] = '{period: 24, hi: 20, pulses: 2};
      vecs[3] = '{period: 7,  hi: 3,  pulses: 3};
      vecs[4] = '{period: 3,  hi: 2,  pulses: 4};

      reset = 1'b1;
      en16 = 1'b0; strobe16 = 1'b0; if16.ready_i = 1'b1;
      en4  = 1'b0; strobe4  = 1'b0; if4.ready_i  = 1'b1;
      repeat (3) tick();
      chk("rst_period", {16'd0, if16.period_o}, 0);
      chk("rst_valid",  if16.valid_o, 0);
      chk("rst_ovf",    ovf16, 0);
      chk("rst_lost",   lost16, 0);
      chk("rst_busy",   busy16, 0);
      chk("rst_valid4", if4.valid_o, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) begin
         en16 = 1'b1;
         tick(); tick();
         for (int unsigned k = 0; k < vecs[i].pulses; k++)
            pulse16(vecs[i].period, vecs[i].hi, k > 0);
         tick(); tick();
         chk("sb_drained", sb.size(), 0);
         chk("vec_busy", busy16, 1);
         chk("vec_lost", lost16, 0);
         chk("vec_ovf",  ovf16, 0);
         en16 = 1'b0;
         tick();
         chk("vec_idle", busy16, 0);
         tick(); tick();
      end

      // backpressure: second result held, third dropped
      if16.ready_i = 1'b0;
      en16 = 1'b1;
      tick(); tick();
      pulse16(6, 1, 1'b0);
      pulse16(6, 1, 1'b1);
      pulse16(6, 1, 1'b0);
      chk("bp_valid",  if16.valid_o, 1);
      chk("bp_period", {16'd0, if16.period_o}, 5);
      chk("bp_lost",   lost16, 1);
      if16.ready_i = 1'b1;
      tick();
      if16.ready_i = 1'b0;
      chk("bp_consumed", if16.valid_o, 0);
      chk("bp_lost_sticky", lost16, 1);
      chk("bp_sb", sb.size(), 0);
      en16 = 1'b0;
      tick();
      chk("bp_lost_clr", lost16, 0);
      if16.ready_i = 1'b1;
      tick();

      // enable drop mid-interval
      en16 = 1'b1;
      tick(); tick();
      strobe16 = 1'b1; tick(); strobe16 = 1'b0;
      repeat (3) tick();
      chk("abort_busy_before", busy16, 1);
      en16 = 1'b0;
      tick();
      chk("abort_busy", busy16, 0);
      chk("abort_valid", if16.valid_o, 0);
      strobe16 = 1'b1; tick(); strobe16 = 1'b0;
      repeat (3) tick();
      chk("abort_no_valid", if16.valid_o, 0);

      // reset mid-interval with a held result
      if16.ready_i = 1'b0;
      en16 = 1'b1;
      tick(); tick();
      pulse16(4, 1, 1'b0);
      pulse16(4, 1, 1'b0);
      chk("pre_rst_valid",  if16.valid_o, 1);
      chk("pre_rst_period", {16'd0, if16.period_o}, 3);
      reset = 1'b1;
      tick();
      chk("mid_rst_valid",  if16.valid_o, 0);
      chk("mid_rst_period", {16'd0, if16.period_o}, 0);
      chk("mid_rst_busy",   busy16, 0);
      chk("mid_rst_lost",   lost16, 0);
      reset = 1'b0;
      en16 = 1'b0;
      if16.ready_i = 1'b1;
      tick();

      // N=4: overflow after a lone pulse, then a full-range 2^N interval
      en4 = 1'b1;
      tick(); tick();
      strobe4 = 1'b1; tick(); strobe4 = 1'b0;
      repeat (15) tick();
      chk("ovf4_early", ovf4, 0);
      chk("ovf4_busy_early", busy4, 1);
      tick();
      chk("ovf4_set", ovf4, 1);
      chk("ovf4_arm", busy4, 0);
      chk("ovf4_no_valid", if4.valid_o, 0);
      tick();
      strobe4 = 1'b1; tick(); strobe4 = 1'b0;
      repeat (15) tick();
      chk("max4_pending", if4.valid_o, 0);
      strobe4 = 1'b1; tick(); strobe4 = 1'b0;
      chk("max4_valid", if4.valid_o, 1);
      chk("max4_period", {28'd0, if4.period_o}, 15);
      chk("max4_ovf_sticky", ovf4, 1);
      tick();
      chk("max4_valid_drop", if4.valid_o, 0);
      en4 = 1'b0;
      tick();
      chk("ovf4_clr", ovf4, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
